// File: rtl/multdiv_unit.sv
// Iterative signed multiplier/divider for the execute stage.
// Shift-add multiply or restoring divide on magnitudes, then sign fix-up; fixed WIDTH+2 edge latency.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 w_start;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    logic                 r_is_div;
    logic                 r_neg;
    logic                 r_bzero;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_dvsr;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_fix_res;
    logic                 r_fix_exc;
    logic [WIDTH-1:0]     r_result;
    logic                 r_exc;
    logic                 r_rdy;

    logic [WIDTH:0]       w_rem_sh;
    logic                 w_rem_ge;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic                 w_mul_exc;
    logic [WIDTH-1:0]     w_quo_s;
    logic                 w_div_exc;
    logic [WIDTH-1:0]     w_div_res;

    assign w_start = ctrl_MULT | ctrl_DIV;

    // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1), so INT_MIN needs no special case.
    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_ge = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_nx = w_rem_ge ? WIDTH'(w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh[WIDTH-1:0];

    assign w_prod_s  = r_neg ? -r_acc : r_acc;
    assign w_mul_exc = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});

    // Only INT_MIN / -1 yields a positive quotient with the top bit set.
    assign w_quo_s   = r_neg ? -r_quo : r_quo;
    assign w_div_exc = r_bzero | (~r_neg & r_quo[WIDTH-1]);
    assign w_div_res = r_bzero ? '0 : w_quo_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_RUN:   w_next = (r_cnt == LAST_ITER) ? S_FIX : S_RUN;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_bzero   <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_dvsr    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_fix_res <= '0;
            r_fix_exc <= 1'b0;
            r_result  <= '0;
            r_exc     <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_is_div <= ~ctrl_MULT;
                r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_bzero  <= (data_operandB == '0);
                r_cnt    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_dvsr   <= w_mag_b;
                r_rem    <= '0;
                r_quo    <= w_mag_a;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_is_div) begin
                            r_rem <= w_rem_nx;
                            r_quo <= {r_quo[WIDTH-2:0], w_rem_ge};
                        end else begin
                            if (r_mplier[0]) begin
                                r_acc <= r_acc + r_mcand;
                            end
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                        end
                    end
                    S_FIX: begin
                        r_fix_res <= r_is_div ? w_div_res : w_prod_s[WIDTH-1:0];
                        r_fix_exc <= r_is_div ? w_div_exc : w_mul_exc;
                    end
                    S_DONE: begin
                        r_result <= r_fix_res;
                        r_exc    <= r_fix_exc;
                        r_rdy    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: arithmetic reference model plus per-cycle output compare.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        cM;
    logic        cD;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (opA),
        .data_operandB (opB),
        .ctrl_MULT     (cM),
        .ctrl_DIV      (cD),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: signed 64-bit product / signed truncating quotient.
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e);
        longint p;
        int     qa;
        int     qb;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            qa = a;
            qb = b;
            r  = 32'(qa / qb);
            e  = 1'b0;
        end
    endfunction

    bit          armed = 1'b0;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] armed_res;
    logic [31:0] pend_res;
    logic [31:0] last_res = 32'h0;
    bit          armed_exc;
    bit          pend_exc;
    bit          last_exc = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_result", data_result, 32'h0);
            chk("rst_exc", 32'(data_exception), 32'h0);
            chk("rst_rdy", 32'(data_resultRDY), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            armed    = 1'b0;
            pend     = 1'b0;
            last_res = 32'h0;
            last_exc = 1'b0;
        end else begin
            if (armed) begin
                pend     = 1'b1;
                cnt      = 0;
                pend_res = armed_res;
                pend_exc = armed_exc;
                armed    = 1'b0;
            end else if (pend) begin
                cnt++;
            end
            if (pend && cnt == 34) begin
                chk("strobe_rdy", 32'(data_resultRDY), 32'h1);
                chk("strobe_result", data_result, pend_res);
                chk("strobe_exc", 32'(data_exception), 32'(pend_exc));
                chk("strobe_busy", 32'(busy), 32'h0);
                last_res = pend_res;
                last_exc = pend_exc;
                pend     = 1'b0;
            end else begin
                chk("rdy_low", 32'(data_resultRDY), 32'h0);
                chk("hold_result", data_result, last_res);
                chk("hold_exc", 32'(data_exception), 32'(last_exc));
                chk("busy", 32'(busy), 32'(pend));
            end
            if (cM | cD) begin
                armed = 1'b1;
                model(cM, opA, opB, armed_res, armed_exc);
            end
        end
    end

    // Called at posedge+1; leaves the pulse high across exactly one rising edge.
    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        cM  = m;
        cD  = d;
        opA = a;
        opB = b;
        @(posedge clock);
        #1;
        cM  = 1'b0;
        cD  = 1'b0;
        opA = $urandom;
        opB = $urandom;
    endtask

    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc);
        pulse(m, d, a, b);
        repeat (36) @(posedge clock);
        #1;
        chk({name, "_result"}, data_result, exp_res);
        chk({name, "_exc"}, 32'(data_exception), 32'(exp_exc));
    endtask

    logic [31:0] mr;
    bit          me;

    initial begin
        reset = 1'b0;
        cM    = 1'b0;
        cD    = 1'b0;
        opA   = 32'h0;
        opB   = 32'h0;
        #1 reset = 1'b1;

        model(1'b1, 32'd7, 32'hFFFF_FFFA, mr, me);
        chk("model_mul_res", mr, 32'hFFFF_FFD6);
        chk("model_mul_exc", 32'(me), 32'h0);
        model(1'b0, 32'hFFFF_FFD5, 32'd5, mr, me);
        chk("model_div_res", mr, 32'hFFFF_FFF8);
        model(1'b1, 32'h0001_0000, 32'h0001_0000, mr, me);
        chk("model_ovf_exc", 32'(me), 32'h1);

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        run_op("t1_mul_neg", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        run_op("t2_mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        run_op("t2_mul_min", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run_op("t3_div_neg", 1'b0, 1'b1, 32'hFFFF_FFD5, 32'd5, 32'hFFFF_FFF8, 1'b0);
        run_op("t3_div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("t4_div_zero", 1'b0, 1'b1, 32'd10, 32'd0, 32'h0, 1'b1);
        run_op("x_mul_min_neg1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("x_mul_neg_neg", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op("x_div_trunc", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("x_div_min_1", 1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run_op("x_div_zero_num", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFB, 32'h0, 1'b0);

        pulse(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #1;
        run_op("t5_abort_div", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("t5_both", 1'b1, 1'b1, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 1'b0);

        pulse(1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (15) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_result", data_result, 32'h0);
        chk("t6_rst_exc", 32'(data_exception), 32'h0);
        chk("t6_rst_rdy", 32'(data_resultRDY), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        run_op("t6_fresh_mul", 1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0);

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
